// File: rtl/cv32e40x_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40x_pkg
// Shared types for the issue controller: FSM state encoding, the execution
// unit selector driven towards EX, and the unit-decode priority function.
// No ports (package).
// -----------------------------------------------------------------------------
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } issue_state_e;

  typedef enum logic [2:0] {
    UNIT_NONE = 3'd0,
    UNIT_ALU  = 3'd1,
    UNIT_MUL  = 3'd2,
    UNIT_DIV  = 3'd3,
    UNIT_LSU  = 3'd4,
    UNIT_CSR  = 3'd5,
    UNIT_SYS  = 3'd6
  } issue_unit_e;

  // Illegal instructions override every enable; among the enables the
  // system/CSR/LSU paths win over the arithmetic units.
  function automatic issue_unit_e decode_unit(
    input logic illegal,
    input logic sys_en,
    input logic csr_en,
    input logic lsu_en,
    input logic div_en,
    input logic mul_en,
    input logic alu_en
  );
    issue_unit_e unit;
    unit = UNIT_NONE;
    if (illegal)     unit = UNIT_NONE;
    else if (sys_en) unit = UNIT_SYS;
    else if (csr_en) unit = UNIT_CSR;
    else if (lsu_en) unit = UNIT_LSU;
    else if (div_en) unit = UNIT_DIV;
    else if (mul_en) unit = UNIT_MUL;
    else if (alu_en) unit = UNIT_ALU;
    return unit;
  endfunction

endpackage

// File: rtl/cv32e40x_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// cv32e40x_issue_ctrl_if
// Bundles the ID-stage decode/handshake signals, EX-side readiness and the
// controller halt/kill lines around the issue controller.
//   master : ID/EX/controller side (drives *_i, observes *_o)
//   slave  : issue controller (observes *_i, drives *_o)
// -----------------------------------------------------------------------------
interface cv32e40x_issue_ctrl_if;
  import cv32e40x_pkg::*;

  logic        id_valid_i;
  logic        alu_en_i;
  logic        mul_en_i;
  logic        div_en_i;
  logic        lsu_en_i;
  logic        csr_en_i;
  logic        sys_en_i;
  logic        illegal_insn_i;
  logic        ex_ready_i;
  logic        div_ready_i;
  logic        halt_i;
  logic        kill_i;

  logic        id_ready_o;
  logic        ex_valid_o;
  issue_unit_e issue_unit_o;
  logic        busy_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output id_valid_i, alu_en_i, mul_en_i, div_en_i, lsu_en_i, csr_en_i,
           sys_en_i, illegal_insn_i, ex_ready_i, div_ready_i, halt_i, kill_i,
    input  id_ready_o, ex_valid_o, issue_unit_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, alu_en_i, mul_en_i, div_en_i, lsu_en_i, csr_en_i,
           sys_en_i, illegal_insn_i, ex_ready_i, div_ready_i, halt_i, kill_i,
    output id_ready_o, ex_valid_o, issue_unit_o, busy_o, stall_cnt_o
  );

endinterface

// File: rtl/cv32e40x_issue_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40x_issue_ctrl
// Issues the decoded ID instruction to EX, selecting the target unit, and
// blocks ID while the multiplier (fixed MUL_CYCLES occupancy) or the divider
// (until div_ready_i) is occupied. Also counts stalled ID cycles.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cv32e40x_issue_ctrl_if.slave (decode inputs, EX/ctrl inputs,
//            id_ready_o / ex_valid_o / issue_unit_o / busy_o / stall_cnt_o)
// Parameter:
//   MUL_CYCLES : multiplier occupancy in cycles, 1..4
// -----------------------------------------------------------------------------
module cv32e40x_issue_ctrl
  import cv32e40x_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  cv32e40x_issue_ctrl_if.slave bus
);

  localparam logic [1:0] MUL_LOAD = 2'(MUL_CYCLES - 1);

  issue_state_e state;
  logic [1:0]   cnt;
  logic [15:0]  stall_cnt;

  issue_unit_e  unit;
  logic         id_ready;
  logic         accept;

  // rst_n gates the combinational outputs so they read as idle while reset
  // is held, independent of whatever the inputs are doing.
  always_comb begin
    unit     = decode_unit(bus.illegal_insn_i, bus.sys_en_i, bus.csr_en_i,
                           bus.lsu_en_i, bus.div_en_i, bus.mul_en_i,
                           bus.alu_en_i);
    id_ready = rst_n && (state == IDLE) && bus.ex_ready_i &&
               !bus.halt_i && !bus.kill_i;
    accept   = bus.id_valid_i && id_ready;
  end

  assign bus.id_ready_o   = id_ready;
  assign bus.ex_valid_o   = accept;
  assign bus.issue_unit_o = rst_n ? unit : UNIT_NONE;
  assign bus.busy_o       = (state != IDLE);
  assign bus.stall_cnt_o  = stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      stall_cnt <= 16'd0;
    end else begin
      // Stall counter is a performance statistic: kill does not touch it.
      if (bus.id_valid_i && !id_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end

      if (bus.kill_i) begin
        state <= IDLE;
        cnt   <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if ((unit == UNIT_MUL) && (MUL_CYCLES > 1)) begin
                state <= MUL_BUSY;
                cnt   <= MUL_LOAD;
              end else if (unit == UNIT_DIV) begin
                state <= DIV_BUSY;
              end
            end
          end
          // cnt holds the remaining blocked cycles including this one.
          MUL_BUSY: begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) begin
              state <= IDLE;
            end
          end
          DIV_BUSY: begin
            if (bus.div_ready_i) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cv32e40x_issue_ctrl
// Self-checking bench for cv32e40x_issue_ctrl with MUL_CYCLES=3. A table of
// per-cycle vectors is driven; each vector's expectations go to a scoreboard
// queue and are popped and compared on the falling edge. Reset, stall
// saturation and reset-during-multiply are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_cv32e40x_issue_ctrl;
  import cv32e40x_pkg::*;

  localparam logic [5:0] EN_NONE = 6'b000000;
  localparam logic [5:0] EN_ALU  = 6'b000001;
  localparam logic [5:0] EN_MUL  = 6'b000010;
  localparam logic [5:0] EN_DIV  = 6'b000100;
  localparam logic [5:0] EN_LSU  = 6'b001000;

  typedef struct {
    string      name;
    logic       valid;
    logic [5:0] en;       // {sys,csr,lsu,div,mul,alu}
    logic       illegal;
    logic       ex_ready;
    logic       div_ready;
    logic       halt;
    logic       kill;
    logic       exp_ready;
    logic       exp_valid;
    logic [2:0] exp_unit;
    logic       exp_busy;
  } vec_t;

  logic clk;
  logic rst_n;
  cv32e40x_issue_ctrl_if bus ();

  cv32e40x_issue_ctrl #(.MUL_CYCLES(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_stall = 16'd0;
  vec_t        vecs[$];
  vec_t        sb[$];

  function automatic vec_t mk(string name, logic valid, logic [5:0] en,
                              logic illegal, logic ex_ready, logic div_ready,
                              logic halt, logic kill, logic exp_ready,
                              logic exp_valid, logic [2:0] exp_unit,
                              logic exp_busy);
    vec_t v;
    v.name = name; v.valid = valid; v.en = en; v.illegal = illegal;
    v.ex_ready = ex_ready; v.div_ready = div_ready; v.halt = halt;
    v.kill = kill; v.exp_ready = exp_ready; v.exp_valid = exp_valid;
    v.exp_unit = exp_unit; v.exp_busy = exp_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid_i     = v.valid;
    bus.alu_en_i       = v.en[0];
    bus.mul_en_i       = v.en[1];
    bus.div_en_i       = v.en[2];
    bus.lsu_en_i       = v.en[3];
    bus.csr_en_i       = v.en[4];
    bus.sys_en_i       = v.en[5];
    bus.illegal_insn_i = v.illegal;
    bus.ex_ready_i     = v.ex_ready;
    bus.div_ready_i    = v.div_ready;
    bus.halt_i         = v.halt;
    bus.kill_i         = v.kill;
  endtask

  // One clock cycle: drive after the rising edge, compare on the falling edge.
  task automatic apply(input vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.name, ".id_ready"},  32'(bus.id_ready_o),   32'(e.exp_ready));
    chk({e.name, ".ex_valid"},  32'(bus.ex_valid_o),   32'(e.exp_valid));
    chk({e.name, ".unit"},      32'(bus.issue_unit_o), 32'(e.exp_unit));
    chk({e.name, ".busy"},      32'(bus.busy_o),       32'(e.exp_busy));
    chk({e.name, ".stall_cnt"}, 32'(bus.stall_cnt_o),  32'(exp_stall));
    $display("vec %-14s ready=%0b valid=%0b unit=%0d busy=%0b stall=%0d",
             e.name, bus.id_ready_o, bus.ex_valid_o, bus.issue_unit_o,
             bus.busy_o, bus.stall_cnt_o);
    if (e.valid && !e.exp_ready && (exp_stall != 16'hFFFF)) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".id_ready"},  32'(bus.id_ready_o),   32'd0);
    chk({tag, ".ex_valid"},  32'(bus.ex_valid_o),   32'd0);
    chk({tag, ".unit"},      32'(bus.issue_unit_o), 32'(UNIT_NONE));
    chk({tag, ".busy"},      32'(bus.busy_o),       32'd0);
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt_o),  32'd0);
    $display("rst %-14s ready=%0b valid=%0b unit=%0d busy=%0b stall=%0d",
             tag, bus.id_ready_o, bus.ex_valid_o, bus.issue_unit_o,
             bus.busy_o, bus.stall_cnt_o);
  endtask

  initial begin
    // name, valid, en, illegal, ex_ready, div_ready, halt, kill |
    //   exp_ready, exp_valid, exp_unit, exp_busy
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk($sformatf("alu%0d", i), 1, EN_ALU, 0,1,0,0,0, 1,1,UNIT_ALU,0));
    vecs.push_back(mk("alu_exstall",  1, EN_ALU, 0,0,0,0,0, 0,0,UNIT_ALU,0));
    vecs.push_back(mk("alu_novalid",  0, EN_ALU, 0,1,0,0,0, 1,0,UNIT_ALU,0));
    vecs.push_back(mk("mul_issue",    1, EN_MUL, 0,1,0,0,0, 1,1,UNIT_MUL,0));
    vecs.push_back(mk("mul_c1",       1, EN_MUL, 0,1,0,0,0, 0,0,UNIT_MUL,1));
    vecs.push_back(mk("mul_c2_divrdy",1, EN_MUL, 0,1,1,0,0, 0,0,UNIT_MUL,1));
    vecs.push_back(mk("mul_c3_issue", 1, EN_MUL, 0,1,0,0,0, 1,1,UNIT_MUL,0));
    vecs.push_back(mk("mul2_c1",      0, EN_ALU, 0,1,0,0,0, 0,0,UNIT_ALU,1));
    vecs.push_back(mk("mul2_c2_halt", 0, EN_NONE,0,1,0,1,0, 0,0,UNIT_NONE,1));
    vecs.push_back(mk("halt_idle",    1, EN_ALU, 0,1,0,1,0, 0,0,UNIT_ALU,0));
    vecs.push_back(mk("div_issue",    1, EN_DIV, 0,1,0,0,0, 1,1,UNIT_DIV,0));
    for (int i = 1; i < 5; i++)
      vecs.push_back(mk($sformatf("div_c%0d", i), 1, EN_ALU, 0,1,0,0,0, 0,0,UNIT_ALU,1));
    vecs.push_back(mk("div_c5_rdy",   1, EN_ALU, 0,1,1,0,0, 0,0,UNIT_ALU,1));
    vecs.push_back(mk("div_c6",       1, EN_ALU, 0,1,0,0,0, 1,1,UNIT_ALU,0));
    vecs.push_back(mk("div2_issue",   1, EN_DIV, 0,1,0,0,0, 1,1,UNIT_DIV,0));
    vecs.push_back(mk("div2_c1",      0, EN_NONE,0,1,0,0,0, 0,0,UNIT_NONE,1));
    vecs.push_back(mk("div2_c2_kill", 1, EN_ALU, 0,1,0,0,1, 0,0,UNIT_ALU,1));
    vecs.push_back(mk("div2_c3_rdy",  0, EN_NONE,0,1,1,0,0, 1,0,UNIT_NONE,0));
    vecs.push_back(mk("div2_c4",      0, EN_NONE,0,1,0,0,0, 1,0,UNIT_NONE,0));
    vecs.push_back(mk("illegal_lsu",  1, EN_LSU, 1,1,0,0,0, 1,1,UNIT_NONE,0));
    vecs.push_back(mk("no_enable",    1, EN_NONE,0,1,0,0,0, 1,1,UNIT_NONE,0));
    vecs.push_back(mk("prio_sys",     1, 6'b111111,0,1,0,0,0, 1,1,UNIT_SYS,0));
    vecs.push_back(mk("prio_csr",     1, 6'b010100,0,1,0,0,0, 1,1,UNIT_CSR,0));
    vecs.push_back(mk("prio_lsu",     1, 6'b001110,0,1,0,0,0, 1,1,UNIT_LSU,0));
    vecs.push_back(mk("prio_div",     0, 6'b000111,0,1,0,0,0, 1,0,UNIT_DIV,0));
    vecs.push_back(mk("prio_mul",     0, 6'b000011,0,1,0,0,0, 1,0,UNIT_MUL,0));
    vecs.push_back(mk("div3_issue",   1, EN_DIV, 0,1,0,0,0, 1,1,UNIT_DIV,0));
    vecs.push_back(mk("div3_rdy_kill",1, EN_ALU, 0,1,1,0,1, 0,0,UNIT_ALU,1));
    vecs.push_back(mk("after_div3",   1, EN_ALU, 0,1,0,0,0, 1,1,UNIT_ALU,0));
    vecs.push_back(mk("kill_idle",    1, EN_ALU, 0,1,0,0,1, 0,0,UNIT_ALU,0));
    vecs.push_back(mk("mul3_issue",   1, EN_MUL, 0,1,0,0,0, 1,1,UNIT_MUL,0));
    vecs.push_back(mk("mul3_kill",    0, EN_NONE,0,1,0,0,1, 0,0,UNIT_NONE,1));
    vecs.push_back(mk("after_mul3",   1, EN_ALU, 0,1,0,0,0, 1,1,UNIT_ALU,0));

    // Reset held with an acceptable instruction presented.
    rst_n = 1'b0;
    drive(mk("rst", 1, EN_ALU, 0,1,0,0,0, 0,0,UNIT_NONE,0));
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table: first vector accepts on the first edge after release.
    foreach (vecs[i]) apply(vecs[i]);

    // Stall counter saturation: 70000 halted cycles with a valid instruction.
    drive(mk("sat", 1, EN_ALU, 0,1,0,1,0, 0,0,UNIT_ALU,0));
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      if (exp_stall != 16'hFFFF) exp_stall++;
    end
    @(negedge clk);
    chk("sat.stall_cnt", 32'(bus.stall_cnt_o), 32'(exp_stall));
    chk("sat.stall_max", 32'(bus.stall_cnt_o), 32'h0000FFFF);
    chk("sat.id_ready",  32'(bus.id_ready_o),  32'd0);
    $display("sat stall=%0h", bus.stall_cnt_o);
    @(posedge clk);
    #1;
    if (exp_stall != 16'hFFFF) exp_stall++;
    apply(mk("sat_hold", 1, EN_ALU, 0,1,0,1,0, 0,0,UNIT_ALU,0));

    // Reset asserted mid multiply: operation abandoned immediately.
    apply(mk("mul4_issue", 1, EN_MUL, 0,1,0,0,0, 1,1,UNIT_MUL,0));
    rst_n = 1'b0;
    drive(mk("rst2", 1, EN_ALU, 0,1,0,0,0, 0,0,UNIT_NONE,0));
    @(negedge clk);
    chk_reset_outputs("reset_mul");
    exp_stall = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(mk("post_rst_alu", 1, EN_ALU, 0,1,0,0,0, 1,1,UNIT_ALU,0));
    apply(mk("post_rst_idle",0, EN_NONE,0,1,0,0,0, 1,0,UNIT_NONE,0));

    if (sb.size() != 0) chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40x_issue_ctrl.md
CV32E40X_ISSUE_CTRL -- requirements
Module: cv32e40x_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter MUL_CYCLES SHALL default to 2 and SHALL be the multiplier occupancy in cycles, legal range 1..4.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 id_valid_i  in  1  ID holds a decoded instruction.
REQ-006 alu_en_i, mul_en_i, div_en_i, lsu_en_i, csr_en_i, sys_en_i  in  1 each  decoded unit enables.
REQ-007 illegal_insn_i  in  1  decoded instruction is illegal.
REQ-008 ex_ready_i  in  1  EX can accept an instruction this cycle.
REQ-009 div_ready_i  in  1  divider result completes this cycle.
REQ-010 halt_i  in  1  controller halt of ID; kill_i  in  1  controller flush of ID/EX.
REQ-011 id_ready_o  out  1  ID instruction consumed this cycle.
REQ-012 ex_valid_o  out  1  instruction issued to EX this cycle.
REQ-013 issue_unit_o  out  3  issue_unit_e selecting the target unit.
REQ-014 busy_o  out  1  a multicycle unit is occupied.
REQ-015 stall_cnt_o  out  16  saturating count of stalled ID cycles.

Function
REQ-016 FSM states SHALL be IDLE, MUL_BUSY and DIV_BUSY.
REQ-017 id_ready_o SHALL equal (state==IDLE) && ex_ready_i && !halt_i && !kill_i.
REQ-018 Acceptance SHALL occur when id_valid_i && id_ready_o; ex_valid_o SHALL equal acceptance, combinationally, with 0-cycle latency.
REQ-019 issue_unit_o priority SHALL be: illegal_insn_i -> UNIT_NONE, then sys -> UNIT_SYS, csr -> UNIT_CSR, lsu -> UNIT_LSU, div -> UNIT_DIV, mul -> UNIT_MUL, alu -> UNIT_ALU, and no enable -> UNIT_NONE.
REQ-020 An illegal instruction or an instruction with no enable SHALL still issue, with UNIT_NONE, and SHALL leave the FSM in IDLE.
REQ-021 Accepting UNIT_MUL with MUL_CYCLES>1 SHALL load cnt with MUL_CYCLES-1 and move to MUL_BUSY.
REQ-022 Accepting UNIT_MUL with MUL_CYCLES==1 SHALL stay in IDLE.
REQ-023 In MUL_BUSY, cnt SHALL decrement each cycle, and the FSM SHALL move to IDLE when cnt==1; ID is therefore blocked for exactly MUL_CYCLES-1 cycles after issue.
REQ-024 Accepting UNIT_DIV SHALL move the FSM to DIV_BUSY.
REQ-025 In DIV_BUSY, the FSM SHALL move to IDLE in the cycle after div_ready_i is sampled high, and id_ready_o SHALL be 0 during the div_ready_i cycle itself.
REQ-026 div_ready_i SHALL be ignored outside DIV_BUSY.
REQ-027 kill_i SHALL take priority over every other event: ex_valid_o=0 that cycle, next state IDLE, cnt cleared to 0.
REQ-028 halt_i SHALL block acceptance only; MUL_BUSY and DIV_BUSY SHALL keep progressing while halt_i is high.
REQ-029 busy_o SHALL equal (state!=IDLE).
REQ-030 stall_cnt_o SHALL increment on every cycle with id_valid_i && !id_ready_o, SHALL saturate at 0xFFFF and hold there, and SHALL NOT be cleared by kill_i.
REQ-031 Simultaneous div_ready_i and kill_i in DIV_BUSY SHALL result in IDLE with no issue.

Reset
REQ-032 While rst_n is low: state=IDLE, cnt=0, stall_cnt_o=0, id_ready_o=0, ex_valid_o=0, issue_unit_o=UNIT_NONE, busy_o=0.
REQ-033 Reset asserted mid MUL_BUSY or DIV_BUSY SHALL abandon the operation immediately.
REQ-034 After release of rst_n, the first acceptance SHALL be possible in the first clock edge.

Structure
REQ-035 issue_state_e (IDLE/MUL_BUSY/DIV_BUSY) and issue_unit_e (UNIT_NONE/ALU/MUL/DIV/LSU/CSR/SYS) SHALL live in cv32e40x_pkg.
REQ-036 The block SHALL contain no sub-module; the FSM, cnt (2 bits) and the stall counter SHALL be local.

Verification
REQ-037 The bench SHALL cover: alu_en_i, id_valid_i, ex_ready_i=1 for 4 cycles -> ex_valid_o=1 every cycle, issue_unit_o=UNIT_ALU, busy_o=0.
REQ-038 The bench SHALL cover: MUL_CYCLES=3, mul issue at cycle 0 with id_valid_i held -> id_ready_o=0 in cycles 1-2, next issue at cycle 3, stall_cnt_o=2.
REQ-039 The bench SHALL cover: div issue, div_ready_i at cycle 5 -> busy_o=1 in cycles 1-5, id_ready_o=1 at cycle 6.
REQ-040 The bench SHALL cover: kill_i in DIV_BUSY at cycle 2 -> ex_valid_o=0 at cycle 2, state IDLE and busy_o=0 at cycle 3, later div_ready_i ignored.
REQ-041 The bench SHALL cover: illegal_insn_i=1 with lsu_en_i=1 -> issue_unit_o=UNIT_NONE, ex_valid_o=1; and 70000 stalled cycles -> stall_cnt_o=0xFFFF.
REQ-042 The bench SHALL cover: rst_n low during MUL_BUSY -> all outputs at reset values; after release, first acceptance on the first edge.
